// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding a shared, stallable LATENCY-stage adder pipeline.
// One accepted operation per cycle; results emerge in acceptance order.
module add_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_carry,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       idle,
  output logic [15:0]                issue_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  next_ptr;
  logic             found;
  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   add_res;

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   sum_q   [LATENCY];
  logic               carry_q [LATENCY];
  logic [ID_W-1:0]    id_q    [LATENCY];

  assign stall  = out_valid & ~out_ready;
  assign accept = found & ~stall & rst;

  always_comb begin
    int unsigned      idx;
    logic [ID_W-1:0]  cand;
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(ptr) + k) % 32'(NUM_REQ);
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[winner] = 1'b1;
  end

  assign next_ptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  assign a_sel   = req_a[int'(winner)*WIDTH +: WIDTH];
  assign b_sel   = req_b[int'(winner)*WIDTH +: WIDTH];
  assign add_res = {1'b0, a_sel} + {1'b0, b_sel};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld         <= '0;
      ptr         <= '0;
      issue_count <= '0;
    end else begin
      if (!stall)
        vld <= LATENCY'({vld, accept});
      if (accept) begin
        ptr         <= next_ptr;
        issue_count <= issue_count + 16'd1;
      end
    end
  end

  // The add is resolved on entry; later stages only carry the result along.
  always_ff @(posedge clk) begin
    if (!stall) begin
      sum_q[0]   <= add_res[WIDTH-1:0];
      carry_q[0] <= add_res[WIDTH];
      id_q[0]    <= winner;
    end
  end

  for (genvar s = 1; s < LATENCY; s++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!stall) begin
        sum_q[s]   <= sum_q[s-1];
        carry_q[s] <= carry_q[s-1];
        id_q[s]    <= id_q[s-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_sum   = sum_q[LATENCY-1];
  assign out_carry = carry_q[LATENCY-1];
  assign out_id    = id_q[LATENCY-1];
  assign idle      = ~|vld;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: vector table, directed corner sequences,
// and random traffic checked against a queue-based timing/result model.
module tb_add_arbiter;

  localparam int N = 2;
  localparam int W = 32;
  localparam int L = 2;
  localparam int IDW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a = '0;
  logic [N*W-1:0]    req_b = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [W-1:0]      out_sum;
  logic              out_carry;
  logic [IDW-1:0]    out_id;
  logic              idle;
  logic [15:0]       issue_count;

  int passed = 0;
  int total  = 0;

  add_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carry   (out_carry),
    .out_id      (out_id),
    .idle        (idle),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight results with the count of advancing cycles at
  // which each one reaches the output.
  typedef struct {
    logic [W-1:0]    sum;
    logic            carry;
    logic [IDW-1:0]  id;
    longint unsigned due;
  } res_t;

  res_t            q[$];
  int              m_ptr   = 0;
  longint unsigned m_adv   = 0;
  logic [15:0]     m_count = '0;

  logic            s_valid;
  logic [W-1:0]    s_sum;
  logic            s_carry;
  logic [IDW-1:0]  s_id;
  logic [N-1:0]    s_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step();
    logic [N-1:0] eg;
    bit           ev;
    bit           stall;
    int           win;
    int           i;
    res_t         r;
    logic [W:0]   full;
    @(negedge clk);
    ev    = (q.size() > 0) && (q[0].due == m_adv);
    stall = ev && !out_ready;
    win   = -1;
    if (!stall)
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (win < 0 && req_valid[i]) win = i;
      end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    s_valid = out_valid; s_sum = out_sum; s_carry = out_carry;
    s_id = out_id; s_ready = req_ready;
    chk("req_ready", req_ready, eg);
    chk("out_valid", out_valid, ev);
    chk("idle", idle, q.size() == 0);
    chk("issue_count", issue_count, m_count);
    if (ev) begin
      chk("out_sum", out_sum, q[0].sum);
      chk("out_carry", out_carry, q[0].carry);
      chk("out_id", out_id, q[0].id);
    end
    if (ev && out_ready) void'(q.pop_front());
    if (win >= 0) begin
      full    = {1'b0, req_a[win*W +: W]} + {1'b0, req_b[win*W +: W]};
      r.sum   = full[W-1:0];
      r.carry = full[W];
      r.id    = IDW'(win);
      r.due   = m_adv + L;
      q.push_back(r);
      m_ptr   = (win + 1) % N;
      m_count = m_count + 16'd1;
    end
    if (!stall) m_adv++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_issue_count", issue_count, 0);
    q.delete();
    m_ptr = 0; m_adv = 0; m_count = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    int           r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int           n;
    logic [7:0]   vbits;
    logic [IDW-1:0] ids[$];
    logic [W-1:0] sums[$];

    tbl[0] = '{0, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
    tbl[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
    tbl[3] = '{1, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
    tbl[4] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    tbl[5] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

    #2;
    do_reset();

    // Single operations from the vector table, one at a time.
    foreach (tbl[i]) begin
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_a[tbl[i].r*W +: W] = tbl[i].a;
      req_b[tbl[i].r*W +: W] = tbl[i].b;
      req_valid = '0;
      req_valid[tbl[i].r] = 1'b1;
      step();
      req_valid = '0;
      n = 0;
      do begin step(); n++; end while (!s_valid && n < 8);
      chk("vec_latency", n, L);
      chk("vec_sum", s_sum, tbl[i].sum);
      chk("vec_carry", s_carry, tbl[i].carry);
      chk("vec_id", s_id, tbl[i].r);
      repeat (2) step();
    end
    chk("vec_issue_count", issue_count, 6);

    // Two requesters back to back: alternating grants and gapless results.
    do_reset();
    req_valid = 2'b11; out_ready = 1'b1;
    vbits = '0; ids.delete();
    for (int c = 0; c < 8; c++) begin
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      if (c == 4) req_valid = '0;
      step();
      if (c < 4) chk("rr_grant", s_ready, (c % 2) ? 2'b10 : 2'b01);
      vbits[c] = s_valid;
      if (s_valid) ids.push_back(s_id);
    end
    chk("rr_valid_pattern", vbits, 8'b0011_1100);
    chk("rr_result_count", ids.size(), 4);
    for (int k = 0; k < 4 && k < ids.size(); k++)
      chk("rr_out_id", ids[k], k % 2);

    // Backpressure with a full pipeline.
    do_reset();
    req_a = {32'd200, 32'd100}; req_b = {32'd2, 32'd1};
    req_valid = 2'b11; out_ready = 1'b0;
    repeat (2) step();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_ready", s_ready, 0);
      chk("stall_valid", s_valid, 1);
      chk("stall_sum", s_sum, 101);
      chk("stall_id", s_id, 0);
    end
    req_valid = '0; out_ready = 1'b1;
    sums.delete();
    for (int c = 0; c < 5; c++) begin
      step();
      if (s_valid) sums.push_back(s_sum);
    end
    chk("stall_drain_count", sums.size(), 2);
    if (sums.size() == 2) begin
      chk("stall_drain_0", sums[0], 101);
      chk("stall_drain_1", sums[1], 202);
    end

    // Reset with operations in flight.
    do_reset();
    req_a = {$urandom, 32'h5}; req_b = {$urandom, 32'h7};
    req_valid = 2'b01;
    repeat (2) step();
    req_valid = 2'b11;
    do_reset();
    step();
    chk("post_rst_grant", s_ready, 2'b01);
    req_valid = '0;
    n = 0;
    for (int c = 0; c < L + 3; c++) begin
      step();
      if (s_valid) n++;
    end
    chk("post_rst_results", n, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) req_a[W-1:0] = '1;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0; out_ready = 1'b1;
    repeat (L + 3) step();

    // Counter wrap after 65536 accepts.
    do_reset();
    req_valid = 2'b11; out_ready = 1'b1;
    repeat (65536) step();
    chk("issue_wrap", issue_count, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
